// File: rtl/mc_cfg_pkg.sv
// Shared definitions for the macrocell configuration path.
// Holds the config word width, the field bit positions inside one word,
// the frame sync patterns and the loader state encoding.
package mc_cfg_pkg;

    localparam int CFGW = 19;

    localparam int PT1_MUX_B      = 0;
    localparam int PT2_MUX_B      = 1;
    localparam int PT3_MUX_B      = 2;
    localparam int PT4_MUX_B      = 3;
    localparam int PT4_FUNC_MUX_B = 4;
    localparam int PT5_MUX_B      = 5;
    localparam int PT5_FUNC_MUX_B = 6;
    localparam int XOR_A_MUX_B    = 7;
    localparam int XOR_B_MUX_B    = 8;
    localparam int XOR_INV_MUX_B  = 9;
    localparam int O_MUX_B        = 10;
    localparam int D_MUX_B        = 11;
    localparam int STORAGE_MUX_B  = 12;
    localparam int OE_MUX_LO      = 13;
    localparam int GCLK_MUX_LO    = 16;
    localparam int GCLR_MUX_B     = 18;

    localparam logic [7:0] SYNC_WR = 8'hA5;
    localparam logic [7:0] SYNC_RD = 8'h5A;

    typedef enum logic [2:0] {
        HUNT,
        W_ADDR,
        W_DATA,
        W_PAR,
        R_ADDR,
        R_PAR,
        RDOUT
    } state_t;

endpackage

// File: rtl/mc_cfg_unpack.sv
// Splits one macrocell config word into its named mux selects.
// Ports: word (config word in); one output per field, oe_mux[2:0] and
// gclk_mux[1:0] take the word bits in ascending order.
module mc_cfg_unpack
    import mc_cfg_pkg::*;
(
    input  logic [CFGW-1:0] word,
    output logic            pt1_mux,
    output logic            pt2_mux,
    output logic            pt3_mux,
    output logic            pt4_mux,
    output logic            pt4_func_mux,
    output logic            pt5_mux,
    output logic            pt5_func_mux,
    output logic            xor_a_mux,
    output logic            xor_b_mux,
    output logic            xor_inv_mux,
    output logic            o_mux,
    output logic            d_mux,
    output logic            storage_mux,
    output logic [2:0]      oe_mux,
    output logic [1:0]      gclk_mux,
    output logic            gclr_mux
);

    assign pt1_mux      = word[PT1_MUX_B];
    assign pt2_mux      = word[PT2_MUX_B];
    assign pt3_mux      = word[PT3_MUX_B];
    assign pt4_mux      = word[PT4_MUX_B];
    assign pt4_func_mux = word[PT4_FUNC_MUX_B];
    assign pt5_mux      = word[PT5_MUX_B];
    assign pt5_func_mux = word[PT5_FUNC_MUX_B];
    assign xor_a_mux    = word[XOR_A_MUX_B];
    assign xor_b_mux    = word[XOR_B_MUX_B];
    assign xor_inv_mux  = word[XOR_INV_MUX_B];
    assign o_mux        = word[O_MUX_B];
    assign d_mux        = word[D_MUX_B];
    assign storage_mux  = word[STORAGE_MUX_B];
    assign oe_mux       = word[OE_MUX_LO +: 3];
    assign gclk_mux     = word[GCLK_MUX_LO +: 2];
    assign gclr_mux     = word[GCLR_MUX_B];

endmodule

// File: rtl/mc_config_loader.sv
// Serial configuration loader for the macrocell array.
// Hunts for a sync byte on the strobed serial link, then either writes a
// parity-checked word into the config store or shifts a stored word back out.
// Ports: ffclk (clock), ffar (async active-high reset), sdi/sdv (serial bit
// and strobe), cfg (all config words, macrocell m at cfg[m*CFGW +: CFGW]),
// sdo/sdo_v (readback bit and valid), frame_ok/frame_err (one-cycle status).
//
// state  | meaning
// HUNT   | sliding 8-bit window looks for a sync byte
// W_ADDR | collecting write address bits
// W_DATA | collecting write data bits
// W_PAR  | waiting for the write parity bit
// R_ADDR | collecting read address bits
// R_PAR  | waiting for the read parity bit
// RDOUT  | free-running shift-out of the addressed word
module mc_config_loader #(
    parameter int NMC  = 16,
    parameter int AW   = $clog2(NMC),
    parameter int CFGW = mc_cfg_pkg::CFGW
) (
    input  logic                ffclk,
    input  logic                ffar,
    input  logic                sdi,
    input  logic                sdv,
    output logic [NMC*CFGW-1:0] cfg,
    output logic                sdo,
    output logic                sdo_v,
    output logic                frame_ok,
    output logic                frame_err
);
    import mc_cfg_pkg::*;

    localparam int            CW        = $clog2(CFGW + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(CFGW - 1);

    state_t          state, state_n;
    logic [7:0]      window, win_n;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   addr_sr;
    logic [CFGW-1:0] data_sr, rd_sr, rd_word;
    logic            par, addr_ok;
    logic            wr_en, err_n, rd_load, rd_last, ok_q;
    logic [CFGW-1:0] mem [NMC];

    // Range check and read mux share one decode so an out-of-range address
    // never indexes past the store.
    always_comb begin
        addr_ok = 1'b0;
        rd_word = '0;
        for (int m = 0; m < NMC; m++) begin
            if (addr_sr == AW'(m)) begin
                addr_ok = 1'b1;
                rd_word = mem[m];
            end
        end
    end

    always_ff @(posedge ffclk or posedge ffar) begin
        if (ffar) state <= HUNT;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        win_n   = {window[6:0], sdi};
        wr_en   = 1'b0;
        err_n   = 1'b0;
        rd_load = 1'b0;
        rd_last = 1'b0;
        case (state)
            HUNT: begin
                if (sdv) begin
                    if (win_n == SYNC_WR)      state_n = W_ADDR;
                    else if (win_n == SYNC_RD) state_n = R_ADDR;
                end
            end
            W_ADDR: if (sdv && cnt == ADDR_LAST) state_n = W_DATA;
            W_DATA: if (sdv && cnt == DATA_LAST) state_n = W_PAR;
            W_PAR: begin
                if (sdv) begin
                    state_n = HUNT;
                    if (sdi == par && addr_ok) wr_en = 1'b1;
                    else                       err_n = 1'b1;
                end
            end
            R_ADDR: if (sdv && cnt == ADDR_LAST) state_n = R_PAR;
            R_PAR: begin
                if (sdv) begin
                    if (sdi == par && addr_ok) begin
                        state_n = RDOUT;
                        rd_load = 1'b1;
                    end else begin
                        state_n = HUNT;
                        err_n   = 1'b1;
                    end
                end
            end
            RDOUT: begin
                if (cnt == DATA_LAST) begin
                    rd_last = 1'b1;
                    state_n = HUNT;
                end
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge ffclk or posedge ffar) begin
        if (ffar) begin
            window    <= '0;
            cnt       <= '0;
            addr_sr   <= '0;
            data_sr   <= '0;
            rd_sr     <= '0;
            par       <= 1'b0;
            ok_q      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ok_q      <= wr_en;
            frame_err <= err_n;

            // Counter restarts on every state change, so each phase counts from 0.
            if (state_n != state)
                cnt <= '0;
            else if (state == RDOUT ||
                     (sdv && (state == W_ADDR || state == W_DATA || state == R_ADDR)))
                cnt <= cnt + 1'b1;

            if (state == HUNT && sdv)
                window <= (state_n == HUNT) ? win_n : 8'h00;

            if (state == HUNT)
                par <= 1'b0;
            else if (sdv && (state == W_ADDR || state == W_DATA || state == R_ADDR))
                par <= par ^ sdi;

            // LSB arrives first, so shift in from the top.
            if (sdv && (state == W_ADDR || state == R_ADDR))
                addr_sr <= {sdi, addr_sr[AW-1:1]};
            if (sdv && state == W_DATA)
                data_sr <= {sdi, data_sr[CFGW-1:1]};

            if (rd_load)
                rd_sr <= rd_word;
            else if (state == RDOUT)
                rd_sr <= rd_sr >> 1;
        end
    end

    always_ff @(posedge ffclk or posedge ffar) begin
        if (ffar) begin
            for (int m = 0; m < NMC; m++) mem[m] <= '0;
        end else begin
            for (int m = 0; m < NMC; m++)
                if (wr_en && addr_sr == AW'(m)) mem[m] <= data_sr;
        end
    end

    for (genvar m = 0; m < NMC; m++) begin : g_cfg
        assign cfg[m*CFGW +: CFGW] = mem[m];
    end

    assign sdo_v    = (state == RDOUT);
    assign sdo      = sdo_v & rd_sr[0];
    assign frame_ok = ok_q | rd_last;

endmodule

// File: doc/mc_config_loader.md
# mc_config_loader

Serial configuration loader for the macrocell array. It receives framed fuse data on a one-bit strobed serial link and writes the per-macrocell mux-select word that the macrocell parts consume: pt1–pt5 routing, XOR selects, output and storage selects, and the OE, gclk and gclr selectors. It also answers read frames by shifting a stored word back out, which gives a fuse-verify path. It sits between the device programming port and the macrocell instances.

## Interface
Parameters:
- NMC, 16, number of macrocells.
- AW, $clog2(NMC), address width.
- CFGW, 19, config word width (fixed by field map).

Ports:
- ffclk  in  1  single clock; all state on rising edge.
- ffar  in  1  asynchronous, active-high reset.
- sdi  in  1  serial data bit.
- sdv  in  1  sdi is valid this cycle (bit strobe).
- cfg  out  NMC*CFGW  config words; macrocell m is cfg[m*CFGW +: CFGW].
- sdo  out  1  readback data bit.
- sdo_v  out  1  sdo valid.
- frame_ok  out  1  one-cycle pulse when a frame completes correctly.
- frame_err  out  1  one-cycle pulse when a frame is rejected.

## Operation
- Word field map, by bit index:
  - [0] pt1_mux, [1] pt2_mux, [2] pt3_mux, [3] pt4_mux, [4] pt4_func_mux.
  - [5] pt5_mux, [6] pt5_func_mux, [7] xor_a_mux, [8] xor_b_mux, [9] xor_inv_mux.
  - [10] o_mux, [11] d_mux, [12] storage_mux.
  - [15:13] oe_mux[0:2], [17:16] gclk_mux[0:1], [18] gclr_mux.
- Only sdv-qualified bits advance any state. Address and data are sent LSB first.
- HUNT: 8-bit sliding window, newest bit enters at LSB.
  - Window == 8'hA5 starts a write frame; window == 8'h5A starts a read frame.
  - The window clears on frame start.
- W_ADDR: AW bits, then W_DATA (CFGW bits), then W_PAR (1 bit).
  - Even parity: the parity bit must equal the XOR of all address and data bits.
  - Accept only if parity matches and addr < NMC.
  - On accept, write the word into cfg at that address and pulse frame_ok.
  - On reject, leave cfg unchanged and pulse frame_err.
  - Either way, return to HUNT.
- R_ADDR: AW bits, then R_PAR (parity = XOR of address bits).
  - If the check passes, go to RDOUT. Otherwise pulse frame_err and return to HUNT.
- RDOUT: runs free, not sdv-paced.
  - Lasts exactly CFGW consecutive cycles with sdo_v=1; sdo carries word bits 0..CFGW-1 in order.
  - frame_ok pulses in the last RDOUT cycle, then return to HUNT.
  - sdi/sdv are ignored during RDOUT; the window is not updated.
- cfg is never partially updated. Non-addressed words never change.

## Timing
- Reset values (asynchronous, immediate on ffar):
  - cfg all zero (oe_mux=000 means output disabled, so the reset state is safe).
  - sdo=0, sdo_v=0, frame_ok=0, frame_err=0.
  - State HUNT, window 0.
- Write latency: cfg update and frame_ok/frame_err are visible in the cycle after the rising edge that samples the parity bit.
- Read latency: the first RDOUT cycle (sdo_v=1, sdo=bit 0) is the cycle after the parity bit is sampled.
- Gaps (sdv=0) of any length inside a frame are legal and hold state. There is no timeout.
- Reset mid-frame: frame abandoned, cfg cleared.
- Back-to-back frames: the next frame's sync bits may begin on the cycle after frame_ok/frame_err.

## Structure
- Shared package mc_cfg_pkg:
  - CFGW and the field bit-index constants (PT1_MUX_B … GCLR_MUX_B, OE_MUX_LO, GCLK_MUX_LO).
  - SYNC_WR=8'hA5, SYNC_RD=8'h5A.
  - State enum {HUNT, W_ADDR, W_DATA, W_PAR, R_ADDR, R_PAR, RDOUT}.
- Sub-module mc_cfg_unpack: pure combinational split of one CFGW word into named mux-select outputs. Each macrocell wrapper instantiates it on its cfg slice.
- Loader body: one FSM, one bit counter (width to cover CFGW), shift registers for address and data, and a running parity bit.

## Test plan
All scenarios use NMC=16, CFGW=19 unless stated.
- Reset: assert ffar mid-simulation → cfg==0, sdo_v==0, no pulses.
- Write: send bits 0x2 (noise), A5, addr 3, data 19'h40001, parity 0 → one cycle after the parity bit, cfg[57+:19]==19'h40001, frame_ok pulses once, all other words 0.
- Bad parity: same frame with parity 1 → cfg unchanged, frame_err pulses, next good frame is accepted.
- Out of range, with NMC=12: write frame to addr 13 with correct parity → frame_err, cfg unchanged.
- Readback after the write scenario: send 5A, addr 3, parity 0 → sdo_v high exactly 19 cycles, sdo = 1, then 17×0, then 1; frame_ok in the last cycle; sdv toggling during RDOUT has no effect.
- Reset mid-W_DATA after 10 data bits → cfg cleared, state HUNT; a complete frame afterwards is accepted normally.
